// File: rtl/l1ca_code_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | l1ca_code_gen : GPS L1 C/A Gold-code generator, one chip per enable strobe. |
// | Optional macro L1CA_SV_LATCH_EN defers sv changes to the next code epoch.   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module l1ca_code_gen #(
  parameter int CHIP_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [4:0]        sv,
  output logic              code,
  output logic              epoch,
  output logic [CHIP_W-1:0] chip
);

  localparam logic [CHIP_W-1:0] c_last_chip = CHIP_W'(1022);

  // Bit i of each register holds LFSR stage i+1, so stage 10 is bit 9.
  logic [9:0]        g1_q, g1_d;
  logic [9:0]        g2_q, g2_d;
  logic [CHIP_W-1:0] chip_q, chip_d;
  logic              w_g1_fb, w_g2_fb, w_wrap;
  logic [4:0]        w_sel;
  logic [3:0]        w_tap_a, w_tap_b;
  logic [9:0]        w_mask;

  assign w_g1_fb = g1_q[2] ^ g1_q[9];
  assign w_g2_fb = g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9];
  assign w_wrap  = en && (chip_q == c_last_chip);

  always_comb begin
    g1_d   = g1_q;
    g2_d   = g2_q;
    chip_d = chip_q;
    if (clear || w_wrap) begin
      g1_d   = '1;
      g2_d   = '1;
      chip_d = '0;
    end else if (en) begin
      g1_d   = {g1_q[8:0], w_g1_fb};
      g2_d   = {g2_q[8:0], w_g2_fb};
      chip_d = chip_q + CHIP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g1_q   <= '1;
      g2_q   <= '1;
      chip_q <= '0;
    end else begin
      g1_q   <= g1_d;
      g2_q   <= g2_d;
      chip_q <= chip_d;
    end
  end

`ifdef L1CA_SV_LATCH_EN
  logic [4:0] sv_q, sv_d;

  // Capture the new PRN only at code boundaries so the period never mixes PRNs.
  always_comb begin
    sv_d = sv_q;
    if (clear || w_wrap) begin
      sv_d = sv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q <= sv;
    end else begin
      sv_q <= sv_d;
    end
  end

  assign w_sel = sv_q;
`else
  assign w_sel = sv;
`endif

  // G2 phase-select taps (stage numbers) for PRN = w_sel + 1.
  always_comb begin
    w_tap_a = 4'd2;
    w_tap_b = 4'd6;
    case (w_sel)
      5'd0:  begin w_tap_a = 4'd2; w_tap_b = 4'd6;  end
      5'd1:  begin w_tap_a = 4'd3; w_tap_b = 4'd7;  end
      5'd2:  begin w_tap_a = 4'd4; w_tap_b = 4'd8;  end
      5'd3:  begin w_tap_a = 4'd5; w_tap_b = 4'd9;  end
      5'd4:  begin w_tap_a = 4'd1; w_tap_b = 4'd9;  end
      5'd5:  begin w_tap_a = 4'd2; w_tap_b = 4'd10; end
      5'd6:  begin w_tap_a = 4'd1; w_tap_b = 4'd8;  end
      5'd7:  begin w_tap_a = 4'd2; w_tap_b = 4'd9;  end
      5'd8:  begin w_tap_a = 4'd3; w_tap_b = 4'd10; end
      5'd9:  begin w_tap_a = 4'd2; w_tap_b = 4'd3;  end
      5'd10: begin w_tap_a = 4'd3; w_tap_b = 4'd4;  end
      5'd11: begin w_tap_a = 4'd5; w_tap_b = 4'd6;  end
      5'd12: begin w_tap_a = 4'd6; w_tap_b = 4'd7;  end
      5'd13: begin w_tap_a = 4'd7; w_tap_b = 4'd8;  end
      5'd14: begin w_tap_a = 4'd8; w_tap_b = 4'd9;  end
      5'd15: begin w_tap_a = 4'd9; w_tap_b = 4'd10; end
      5'd16: begin w_tap_a = 4'd1; w_tap_b = 4'd4;  end
      5'd17: begin w_tap_a = 4'd2; w_tap_b = 4'd5;  end
      5'd18: begin w_tap_a = 4'd3; w_tap_b = 4'd6;  end
      5'd19: begin w_tap_a = 4'd4; w_tap_b = 4'd7;  end
      5'd20: begin w_tap_a = 4'd5; w_tap_b = 4'd8;  end
      5'd21: begin w_tap_a = 4'd6; w_tap_b = 4'd9;  end
      5'd22: begin w_tap_a = 4'd1; w_tap_b = 4'd3;  end
      5'd23: begin w_tap_a = 4'd4; w_tap_b = 4'd6;  end
      5'd24: begin w_tap_a = 4'd5; w_tap_b = 4'd7;  end
      5'd25: begin w_tap_a = 4'd6; w_tap_b = 4'd8;  end
      5'd26: begin w_tap_a = 4'd7; w_tap_b = 4'd9;  end
      5'd27: begin w_tap_a = 4'd8; w_tap_b = 4'd10; end
      5'd28: begin w_tap_a = 4'd1; w_tap_b = 4'd6;  end
      5'd29: begin w_tap_a = 4'd2; w_tap_b = 4'd7;  end
      5'd30: begin w_tap_a = 4'd3; w_tap_b = 4'd8;  end
      5'd31: begin w_tap_a = 4'd4; w_tap_b = 4'd9;  end
      default: begin w_tap_a = 4'd2; w_tap_b = 4'd6; end
    endcase
  end

  assign w_mask = (10'd1 << (w_tap_a - 4'd1)) | (10'd1 << (w_tap_b - 4'd1));
  assign code   = g1_q[9] ^ (^(g2_q & w_mask));
  assign epoch  = (chip_q == '0);
  assign chip   = chip_q;

endmodule
`default_nettype wire

// File: tb/tb_l1ca_code_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_l1ca_code_gen : scoreboard bench for the L1 C/A code generator.          |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_l1ca_code_gen;

  typedef struct packed {
    logic       code;
    logic       epoch;
    logic [9:0] chip;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] sv = 5'd0;
  logic       code;
  logic       epoch;
  logic [9:0] chip;

  l1ca_code_gen #(.CHIP_W(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .sv    (sv),
    .code  (code),
    .epoch (epoch),
    .chip  (chip)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference Gold sequences built from independent stage-numbered LFSRs.
  logic seq [32][1023];
  int   ta [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int   tb [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  task automatic build_model();
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int s = 0; s < 32; s++) begin
      for (int k = 1; k <= 10; k++) begin g1[k] = 1'b1; g2[k] = 1'b1; end
      for (int c = 0; c < 1023; c++) begin
        seq[s][c] = g1[10] ^ g2[ta[s]] ^ g2[tb[s]];
        f1 = g1[3] ^ g1[10];
        f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        for (int k = 10; k >= 2; k--) begin g1[k] = g1[k-1]; g2[k] = g2[k-1]; end
        g1[1] = f1;
        g2[1] = f2;
      end
    end
  endtask

  int         m_chip = 0;
  logic [4:0] m_sel  = 5'd0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every pushed expectation is compared on the falling edge after it.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("chip", int'(chip), int'(e.chip));
      check("epoch", int'(epoch), int'(e.epoch));
      check("code", int'(code), int'(e.code));
    end
  end

  // One clock edge of stimulus; hand >= 0 overrides the model's code value.
  task automatic step(input logic e_i, input logic c_i, input logic r_i,
                      input logic [4:0] s_i, input int hand);
    exp_t x;
    logic [4:0] eff;
    @(negedge clk);
    #1;
    en = e_i; clear = c_i; rst = r_i; sv = s_i;
    @(posedge clk);
    #1;
    if (r_i || c_i) begin
      m_chip = 0; m_sel = s_i;
    end else if (e_i) begin
      if (m_chip == 1022) begin m_chip = 0; m_sel = s_i; end
      else m_chip = m_chip + 1;
    end
`ifdef L1CA_SV_LATCH_EN
    eff = m_sel;
`else
    eff = s_i;
`endif
    x.chip  = 10'(m_chip);
    x.epoch = (m_chip == 0);
    x.code  = (hand >= 0) ? hand[0] : seq[eff][m_chip];
    q.push_back(x);
  endtask

  task automatic run_to(input int target, input logic [4:0] s_i);
    int guard = 0;
    while (m_chip != target && guard < 2100) begin
      step(1'b1, 1'b0, 1'b0, s_i, -1);
      guard++;
    end
  endtask

  int prn1_hand [10] = '{1,1,0,0,1,0,0,0,0,0};
  int prn2_hand [10] = '{1,1,1,0,0,1,0,0,0,0};

  initial begin
    build_model();

    // Reset state and PRN1 first ten chips (octal 1440).
    step(1'b1, 1'b0, 1'b1, 5'd0, prn1_hand[0]);
    for (int i = 1; i < 10; i++) step(1'b1, 1'b0, 1'b0, 5'd0, prn1_hand[i]);
    run_to(1022, 5'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, -1);

    // PRN2 first ten chips (octal 1620) after clear.
    step(1'b0, 1'b1, 1'b0, 5'd1, prn2_hand[0]);
    for (int i = 1; i < 10; i++) step(1'b1, 1'b0, 1'b0, 5'd1, prn2_hand[i]);

    // Full period for every PRN, including the wrap back to chip 0.
    for (int s = 0; s < 32; s++) begin
      step(1'b0, 1'b1, 1'b0, 5'(s), -1);
      for (int c = 0; c < 1023; c++) step(1'b1, 1'b0, 1'b0, 5'(s), -1);
    end

    // Clear mid-period, then clear together with en.
    step(1'b0, 1'b1, 1'b0, 5'd4, -1);
    run_to(500, 5'd4);
    step(1'b0, 1'b1, 1'b0, 5'd4, -1);
    run_to(37, 5'd4);
    step(1'b1, 1'b1, 1'b0, 5'd4, -1);

    // Enable gaps of random length must hold chip and code.
    for (int i = 0; i < 20; i++) begin
      int hold;
      hold = int'($urandom_range(1, 5));
      for (int h = 0; h < hold; h++) step(1'b0, 1'b0, 1'b0, 5'd4, -1);
      step(1'b1, 1'b0, 1'b0, 5'd4, -1);
    end

    // PRN change at chip 500, carried through the next wrap.
    step(1'b0, 1'b1, 1'b0, 5'd6, -1);
    run_to(500, 5'd6);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 5'd20, -1);
    run_to(1022, 5'd20);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 5'd20, -1);

    // Reset mid-period while enabled.
    run_to(300, 5'd20);
    step(1'b1, 1'b0, 1'b1, 5'd9, -1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 5'd9, -1);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
